weight_load_ctrl: RTL

- Sequences one weight-tile load into the systolic array (sysArr) through the weight FIFO (weightFifo).
- On start, reads ROWS weight rows from weight memory and pushes them into the FIFO.
- Then drains the FIFO into the array with wwrite asserted and pulses done.
- Sits between the top-level controller/host and the FIFO + MMU pair.

---
 rtl/weight_load_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/weight_load_ctrl.sv
// Weight-tile load sequencer: reads ROWS rows from weight memory into weightFifo, then drains the FIFO into sysArr.
// Optional abort path enabled by defining WEIGHT_LOAD_CTRL_ABORT_EN.
module weight_load_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_DIM  = 4,
    parameter int ROWS       = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    output logic                            busy,
    output logic                            done,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [DATA_WIDTH*ARRAY_DIM-1:0] mem_rdata,
    output logic                            fifo_en,
    output logic [DATA_WIDTH*ARRAY_DIM-1:0] fifo_weightIn,
    output logic [ARRAY_DIM-1:0]            mmu_wwrite
`ifdef WEIGHT_LOAD_CTRL_ABORT_EN
    ,
    input  logic                            abort,
    output logic                            aborted
`endif
);

    localparam int ROW_W   = DATA_WIDTH * ARRAY_DIM;
    localparam int CNT_MAX = (ROWS > ARRAY_DIM) ? ROWS : ARRAY_DIM;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(ARRAY_DIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    mem_rd_en_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    fifo_en_q;
    logic [ROW_W-1:0]        fifo_weightIn_q;
    logic [ARRAY_DIM-1:0]    mmu_wwrite_q;
`ifdef WEIGHT_LOAD_CTRL_ABORT_EN
    logic                    aborted_q;
`endif

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Outputs are registered with the state they belong to, so they are valid
    // in the same cycle as the state. mem_rdata is captured on the edge that
    // closes each read cycle and presented as the push in the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every output register sits in the async reset; an abort
            // must never leave a strobe or a stale data word driving the FIFO.
            state_q         <= IDLE;
            cnt_q           <= '0;
            base_q          <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_rd_en_q     <= 1'b0;
            mem_addr_q      <= '0;
            fifo_en_q       <= 1'b0;
            fifo_weightIn_q <= '0;
            mmu_wwrite_q    <= '0;
`ifdef WEIGHT_LOAD_CTRL_ABORT_EN
            aborted_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= FILL;
                        cnt_q       <= '0;
                        base_q      <= base_addr;
                        busy_q      <= 1'b1;
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= base_addr;
                    end
                end
                FILL: begin
                    if (cnt_q == FILL_LAST) begin
                        state_q         <= WRITE;
                        cnt_q           <= '0;
                        mem_rd_en_q     <= 1'b0;
                        fifo_en_q       <= 1'b1;
                        fifo_weightIn_q <= '0;
                        mmu_wwrite_q    <= '1;
                    end else begin
                        cnt_q           <= cnt_inc;
                        mem_rd_en_q     <= (cnt_q != READ_LAST);
                        fifo_en_q       <= 1'b1;
                        fifo_weightIn_q <= mem_rdata;
                        if (cnt_q != READ_LAST) begin
                            // Wraps modulo 2^ADDR_WIDTH by construction.
                            mem_addr_q <= base_q + ADDR_WIDTH'(cnt_inc);
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == WRITE_LAST) begin
                        state_q      <= DONE;
                        cnt_q        <= '0;
                        done_q       <= 1'b1;
                        fifo_en_q    <= 1'b0;
                        mmu_wwrite_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

`ifdef WEIGHT_LOAD_CTRL_ABORT_EN
            // Placed after the case so it overrides whatever the case scheduled.
            aborted_q <= 1'b0;
            if (abort && (state_q == FILL || state_q == WRITE)) begin
                state_q         <= IDLE;
                cnt_q           <= '0;
                busy_q          <= 1'b0;
                done_q          <= 1'b0;
                mem_rd_en_q     <= 1'b0;
                fifo_en_q       <= 1'b0;
                fifo_weightIn_q <= '0;
                mmu_wwrite_q    <= '0;
                aborted_q       <= 1'b1;
            end
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_rd_en     = mem_rd_en_q;
    assign mem_addr      = mem_addr_q;
    assign fifo_en       = fifo_en_q;
    assign fifo_weightIn = fifo_weightIn_q;
    assign mmu_wwrite    = mmu_wwrite_q;
`ifdef WEIGHT_LOAD_CTRL_ABORT_EN
    assign aborted       = aborted_q;
`endif

endmodule
